bus_if: RTL and testbench
=========================

BUS_IF -- requirements
Module: bus_if

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port stall, input, 1 bit: pipeline stall; data is held while it is high.
REQ-004 The block SHALL have port flush, input, 1 bit: pipeline flush; cancels a not-yet-granted access.
REQ-005 The block SHALL have port addr, input, 30 bits: word address from the pipeline.
REQ-006 The block SHALL have port as_, input, 1 bit: address strobe from the pipeline, active-low.
REQ-007 The block SHALL have port rw, input, 1 bit: 1 = read, 0 = write.
REQ-008 The block SHALL have port wr_data, input, 32 bits: write data from the pipeline.
REQ-009 The block SHALL have port rd_data, output, 32 bits: read data to the pipeline.
REQ-010 The block SHALL have port busy, output, 1 bit: pipeline must stall while high.
REQ-011 The block SHALL have port err, output, 1 bit: access-timeout pulse.
REQ-012 The block SHALL have port bus_req_, output, 1 bit: request to the arbiter, active-low.
REQ-013 The block SHALL have port bus_grnt_, input, 1 bit: grant from the arbiter, active-low.
REQ-014 The block SHALL have bus-side outputs bus_addr (30 bits), bus_as_ (1 bit, active-low), bus_rw (1 bit) and bus_wr_data (32 bits).
REQ-015 The block SHALL have bus-side inputs bus_rd_data (32 bits) and bus_rdy_ (1 bit, active-low).

Function
REQ-016 The FSM SHALL have states IDLE, REQ, ACCESS and STALL.
REQ-017 In IDLE with as_=0 and flush=0, the FSM SHALL register bus_req_=0 and latch addr/rw/wr_data into bus_addr/bus_rw/bus_wr_data, then go to REQ.
REQ-018 In IDLE with flush=1, the block SHALL start no request.
REQ-019 busy SHALL be combinational: 1 in IDLE when as_=0 and flush=0, 1 in REQ, 1 in ACCESS while bus_rdy_=1, 0 otherwise.
REQ-020 In REQ with bus_grnt_=0, the FSM SHALL register bus_as_=0 for exactly one cycle and go to ACCESS.
REQ-021 In REQ with flush=1 and bus_grnt_=1, the FSM SHALL register bus_req_=1 and return to IDLE; if grant and flush occur in the same cycle, grant wins.
REQ-022 bus_req_ SHALL remain 0 from REQ through the whole of ACCESS (bus lock held).
REQ-023 In ACCESS, flush SHALL be ignored and the transaction SHALL always complete.
REQ-024 In ACCESS with bus_rdy_=0, the block SHALL drive rd_data=bus_rd_data combinationally, capture it into rd_buf, and register bus_req_=1.
REQ-025 Following REQ-024, the FSM SHALL go to STALL if stall=1, else to IDLE.
REQ-026 For a write (bus_rw=0), rd_data SHALL be driven as 0 at completion.
REQ-027 In STALL, rd_data SHALL equal rd_buf and busy SHALL be 0; the FSM SHALL go to IDLE when stall=0.
REQ-028 In IDLE and REQ, rd_data SHALL be 0.
REQ-029 The minimum latency from as_ to data SHALL be 3 cycles: IDLE, then REQ with grant, then ACCESS with rdy in the first cycle.
REQ-030 A new request in the IDLE cycle that immediately follows a completion SHALL be accepted (back-to-back access).

Reset
REQ-031 While reset=1, regardless of clk, the block SHALL force: state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, rd_buf=0, err=0, timeout counter=0.
REQ-032 Reset asserted mid-ACCESS SHALL abandon the transaction; bus_req_ and bus_as_ go to 1 immediately.

Configuration
REQ-033 With BUS_IF_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to ACCESS and increment in each ACCESS cycle with bus_rdy_=1.
REQ-034 With BUS_IF_TIMEOUT_EN defined, when the counter reaches 255 the block SHALL pulse err=1 for one cycle, register bus_req_=1, drop busy, and return to IDLE with rd_buf unchanged.
REQ-035 Without BUS_IF_TIMEOUT_EN, the counter SHALL be absent, err SHALL be tied to 0, and ACCESS SHALL wait indefinitely for bus_rdy_.

Verification
REQ-036 Read, grant and rdy immediate: as_=0, rw=1, addr=30'h100 -> bus_req_=0 at cycle 1, bus_as_=0 at cycle 2, bus_addr=30'h100; bus_rdy_=0 with bus_rd_data=32'hDEADBEEF at cycle 3 -> rd_data=32'hDEADBEEF, busy=0 that cycle.
REQ-037 Write with 4-cycle rdy delay: rw=0, wr_data=32'h12345678 -> bus_wr_data stable for 4 ACCESS cycles, busy=1 throughout, rd_data=0 at completion.
REQ-038 Flush before grant: hold bus_grnt_=1, assert flush in REQ -> bus_req_=1 next cycle, FSM in IDLE, bus_as_ never asserted.
REQ-039 Stall at completion: stall=1 when bus_rdy_=0 with bus_rd_data=32'hA5A5A5A5 -> rd_data holds 32'hA5A5A5A5 until stall=0, then returns to 0.
REQ-040 Timeout, macro defined: bus_rdy_ held at 1 -> err=1 for one cycle after 255 ACCESS cycles, bus_req_=1, busy=0.
REQ-041 Timeout, macro undefined: bus_rdy_ held at 1 -> busy stays 1 and err stays 0.
REQ-042 Reset during ACCESS: bus_req_=1 and bus_as_=1 immediately; after release, state=IDLE.

Source files
------------

// File: rtl/bus_if_if.sv
// Pipeline-side and arbitrated-bus-side signal bundle for the bus_if bridge.
// The slave modport is the bridge's view; master is the pipeline/bus environment.
interface bus_if_if;
  logic        stall;
  logic        flush;
  logic [29:0] addr;
  logic        as_;
  logic        rw;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy;
  logic        err;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  modport slave (
    input  stall, flush, addr, as_, rw, wr_data, bus_grnt_, bus_rd_data, bus_rdy_,
    output rd_data, busy, err, bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );

  modport master (
    output stall, flush, addr, as_, rw, wr_data, bus_grnt_, bus_rd_data, bus_rdy_,
    input  rd_data, busy, err, bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );
endinterface

// File: rtl/bus_if.sv
// Pipeline-to-shared-bus bridge: requests the arbiter, runs one locked access, returns read data.
// Define BUS_IF_TIMEOUT_EN to abort an access after 255 not-ready cycles with an err pulse.
module bus_if (
  input  logic     clk,
  input  logic     reset,
  bus_if_if.slave  bif
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_as_q, bus_as_d;
  logic        bus_rw_q, bus_rw_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [31:0] rd_data;
  logic        busy;
  logic        timeout;

`ifdef BUS_IF_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Counter restarts on the grant that enters ACCESS; 255 not-ready cycles trip the timeout.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (state_q == REQ && !bif.bus_grnt_) begin
      cnt_d = 8'd0;
    end else if (state_q == ACCESS && bif.bus_rdy_) begin
      cnt_d   = cnt_q + 8'd1;
      timeout = (cnt_q == 8'd254);
    end
    err_d = timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bif.err = err_q;
`else
  assign timeout = 1'b0;
  assign bif.err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    rd_data       = 32'd0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bif.as_ && !bif.flush) begin
          busy          = 1'b1;
          bus_req_d     = 1'b0;
          bus_addr_d    = bif.addr;
          bus_rw_d      = bif.rw;
          bus_wr_data_d = bif.wr_data;
          state_d       = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        // Grant takes priority over a simultaneous flush.
        if (!bif.bus_grnt_) begin
          bus_as_d = 1'b0;
          state_d  = ACCESS;
        end else if (bif.flush) begin
          bus_req_d = 1'b1;
          state_d   = IDLE;
        end
      end
      ACCESS: begin
        bus_as_d = 1'b1;
        if (!bif.bus_rdy_) begin
          rd_data   = bus_rw_q ? bif.bus_rd_data : 32'd0;
          rd_buf_d  = rd_data;
          bus_req_d = 1'b1;
          state_d   = bif.stall ? STALL : IDLE;
        end else begin
          busy = 1'b1;
          if (timeout) begin
            bus_req_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      STALL: begin
        rd_data = rd_buf_q;
        if (!bif.stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= 30'd0;
      bus_wr_data_q <= 32'd0;
      rd_buf_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
    end
  end

  assign bif.rd_data     = rd_data;
  assign bif.busy        = busy;
  assign bif.bus_req_    = bus_req_q;
  assign bif.bus_as_     = bus_as_q;
  assign bif.bus_rw      = bus_rw_q;
  assign bif.bus_addr    = bus_addr_q;
  assign bif.bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_if.sv
// Bench for bus_if: directed scenarios plus randomized transactions checked against
// a transaction-level expectation (latency, read/write data, bus lock, stall hold).
module tb_bus_if;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  bus_if_if bif();

  bus_if dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One complete transaction: gd cycles without grant, rdly not-ready cycles,
  // st cycles spent in the stall-hold state after completion.
  task automatic txn(input bit rw_i, input logic [29:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int gd, input int rdly, input int st);
    logic [31:0] exp_rd;
    exp_rd = rw_i ? rd : 32'd0;
    @(negedge clk);
    bif.as_ = 1'b0; bif.rw = rw_i; bif.addr = a; bif.wr_data = wd;
    bif.flush = 1'b0; bif.stall = 1'b0; bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1;
    #1;
    chk("idle_busy", bif.busy, 1);
    chk("idle_rd_data", bif.rd_data, 0);
    chk("idle_bus_req", bif.bus_req_, 1);
    chk("idle_bus_as", bif.bus_as_, 1);
    for (int i = 0; i <= gd; i++) begin
      @(negedge clk);
      bif.as_ = 1'b1; bif.addr = 30'($urandom); bif.wr_data = $urandom; bif.rw = ~rw_i;
      bif.bus_grnt_ = (i == gd) ? 1'b0 : 1'b1;
      bif.flush = (i == gd) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk("req_bus_req", bif.bus_req_, 0);
      chk("req_busy", bif.busy, 1);
      chk("req_bus_as", bif.bus_as_, 1);
      chk("req_rd_data", bif.rd_data, 0);
    end
    for (int i = 0; i <= rdly; i++) begin
      @(negedge clk);
      bif.flush = 1'($urandom_range(0, 1));
      bif.bus_grnt_ = 1'b1;
      bif.bus_rdy_ = (i == rdly) ? 1'b0 : 1'b1;
      bif.bus_rd_data = (i == rdly) ? rd : $urandom;
      bif.stall = (i == rdly && st > 0) ? 1'b1 : 1'b0;
      #1;
      chk("acc_bus_as", bif.bus_as_, (i == 0) ? 1'b0 : 1'b1);
      chk("acc_bus_req", bif.bus_req_, 0);
      chk("acc_bus_addr", bif.bus_addr, a);
      chk("acc_bus_rw", bif.bus_rw, rw_i);
      if (!rw_i) chk("acc_bus_wr_data", bif.bus_wr_data, wd);
      chk("acc_busy", bif.busy, (i == rdly) ? 1'b0 : 1'b1);
      if (i == rdly) chk("acc_rd_data", bif.rd_data, exp_rd);
    end
    for (int i = 0; i < st; i++) begin
      @(negedge clk);
      bif.flush = 1'b0; bif.bus_rdy_ = 1'b1; bif.bus_rd_data = $urandom;
      bif.stall = (i < st - 1) ? 1'b1 : 1'b0;
      #1;
      chk("stall_rd_data", bif.rd_data, exp_rd);
      chk("stall_busy", bif.busy, 0);
      chk("stall_bus_req", bif.bus_req_, 1);
    end
    bif.flush = 1'b0;
    bif.stall = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    bif.stall = 1'b0; bif.flush = 1'b0; bif.addr = 30'd0; bif.as_ = 1'b1;
    bif.rw = 1'b1; bif.wr_data = 32'd0; bif.bus_grnt_ = 1'b1;
    bif.bus_rd_data = 32'd0; bif.bus_rdy_ = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_bus_req", bif.bus_req_, 1);
    chk("rst_bus_as", bif.bus_as_, 1);
    chk("rst_bus_rw", bif.bus_rw, 1);
    chk("rst_bus_addr", bif.bus_addr, 0);
    chk("rst_bus_wr_data", bif.bus_wr_data, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_rd_data", bif.rd_data, 0);
    chk("rst_busy", bif.busy, 0);
    @(negedge clk); reset = 1'b0;

    // Immediate read, then 4-cycle-delayed write, then stall at completion
    txn(1'b1, 30'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    txn(1'b0, 30'h2AB, 32'h12345678, 32'hFFFF0000, 0, 4, 0);
    txn(1'b1, 30'h3C0, 32'h0, 32'hA5A5A5A5, 1, 0, 3);

    // Flush in IDLE starts nothing
    @(negedge clk);
    bif.as_ = 1'b0; bif.flush = 1'b1; bif.bus_grnt_ = 1'b0; #1;
    chk("idle_flush_busy", bif.busy, 0);
    @(negedge clk);
    bif.as_ = 1'b1; bif.flush = 1'b0; bif.bus_grnt_ = 1'b1; #1;
    chk("idle_flush_req", bif.bus_req_, 1);

    // Flush before grant aborts the request
    @(negedge clk);
    bif.as_ = 1'b0; bif.rw = 1'b1; bif.addr = 30'h55; #1;
    @(negedge clk);
    bif.as_ = 1'b1; bif.flush = 1'b1; bif.bus_grnt_ = 1'b1; #1;
    chk("flush_req_busy", bif.busy, 1);
    @(negedge clk);
    bif.flush = 1'b0; #1;
    chk("flush_bus_req", bif.bus_req_, 1);
    chk("flush_bus_as", bif.bus_as_, 1);
    chk("flush_busy", bif.busy, 0);
    @(negedge clk); #1;
    chk("flush_bus_as2", bif.bus_as_, 1);

    // Reset during ACCESS abandons the access immediately
    @(negedge clk);
    bif.as_ = 1'b0; bif.rw = 1'b1; bif.addr = 30'h777; #1;
    @(negedge clk);
    bif.as_ = 1'b1; bif.bus_grnt_ = 1'b0; #1;
    @(negedge clk);
    bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1; #1;
    chk("pre_rst_bus_as", bif.bus_as_, 0);
    reset = 1'b1; #1;
    chk("mid_rst_bus_req", bif.bus_req_, 1);
    chk("mid_rst_bus_as", bif.bus_as_, 1);
    chk("mid_rst_bus_addr", bif.bus_addr, 0);
    chk("mid_rst_busy", bif.busy, 0);
    @(negedge clk); reset = 1'b0;
    txn(1'b1, 30'h0ABC, 32'h0, 32'h0BADF00D, 0, 0, 0);

    // Timeout behaviour with bus_rdy_ held high
    @(negedge clk);
    bif.as_ = 1'b0; bif.rw = 1'b1; bif.addr = 30'h321; #1;
    @(negedge clk);
    bif.as_ = 1'b1; bif.bus_grnt_ = 1'b0; #1;
`ifdef BUS_IF_TIMEOUT_EN
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1; #1;
      chk("to_wait_busy", bif.busy, 1);
      chk("to_wait_err", bif.err, 0);
    end
    @(negedge clk); #1;
    chk("to_err", bif.err, 1);
    chk("to_bus_req", bif.bus_req_, 1);
    chk("to_busy", bif.busy, 0);
    @(negedge clk); #1;
    chk("to_err_pulse", bif.err, 0);
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1; #1;
      chk("nto_busy", bif.busy, 1);
      chk("nto_err", bif.err, 0);
    end
    @(negedge clk);
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h600DCAFE; #1;
    chk("nto_rd_data", bif.rd_data, 32'h600DCAFE);
    chk("nto_done_busy", bif.busy, 0);
`endif

    // Randomized back-to-back transactions
    for (int k = 0; k < 25; k++) begin
      txn(1'($urandom_range(0, 1)), 30'($urandom), $urandom, $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end
    @(negedge clk); #1;
    chk("end_bus_req", bif.bus_req_, 1);
    chk("end_rd_data", bif.rd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
